keypad_entry: RTL and testbench
===============================

# keypad_entry

Parametrised keypad entry buffer that collects up to NDIGITS BCD digits from the keypad decoder into a display register, with backspace, clear and enter/commit keys. It sits between the keypad scanner (`ready` strobe plus 4-bit `tecla` code) and the 7-segment display drivers. It generalises the two-digit alternating entry block in three ways:
- N digits instead of two.
- Selectable wrap or shift-in fill mode.
- A single synchronous clock domain with a synchronised, edge-detected `ready`.

## Interface
Parameters:
- NDIGITS, 4: number of BCD digits held (≥2).
- MODE, 0: 0 = WRAP (MSB-first fill, pointer wraps); 1 = SHIFT (calculator style, new digit enters at digit 0).
- RELEASE_CYC, 4: consecutive cycles `ready` must be low before the next press is accepted (≥1).

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- ready  in  1  keypad strobe, asynchronous to clk; high while a key is held.
- tecla  in  4  key code; stable while `ready` is high.
- digits  out  4*NDIGITS  live entry buffer; digit i at bits [4i+3:4i]; digit NDIGITS-1 is leftmost.
- count  out  $clog2(NDIGITS+1)  number of valid digits entered.
- value  out  4*NDIGITS  last committed entry.
- valid  out  1  one-cycle pulse when `value` is updated.
- overflow  out  1  one-cycle pulse when a digit is accepted while count == NDIGITS.

## Operation
Key codes:
- 0–9: digit.
- 4'hA: BKSP.
- 4'hB: CLR.
- 4'hC: ENT.
- 4'hD–4'hF: ignored, but the press still consumes the FSM.

FSM, with states IDLE, HELD and RELEASE:
- IDLE: on the synchronised rising edge of `ready`, execute the key action and go to HELD.
- HELD: wait for synchronised `ready` low, then go to RELEASE and load the release counter with RELEASE_CYC-1.
- RELEASE: decrement the counter while `ready` is low. If `ready` goes high, return to HELD; that press is discarded as bounce. When the counter reaches 0 with `ready` low, go to IDLE.

Digit action in WRAP mode:
- Write to digit `ptr`. `ptr` starts at NDIGITS-1 and decrements modulo NDIGITS, wrapping from 0 to NDIGITS-1.
- `count` saturates at NDIGITS.

Digit action in SHIFT mode:
- Shift `digits` left by one digit; the new digit goes into digit 0 and the old top digit is dropped.
- `count` saturates at NDIGITS.

Digit action, both modes:
- If `count` == NDIGITS before the write, pulse `overflow`.

BKSP:
- count == 0: no-op.
- WRAP mode: `ptr` increments modulo NDIGITS (inverse of the digit step), the digit at the new `ptr` is cleared to 0, and `count` decrements.
- SHIFT mode: shift right by one digit, 0 enters the top digit, and `count` decrements.

CLR:
- `digits` is cleared to 0, `count` to 0, and `ptr` to NDIGITS-1.
- `value` is unchanged.

ENT:
- `value` takes `digits`, `valid` pulses, and the buffer clears as for CLR.
- ENT with count == 0 still commits zeros and pulses `valid`.

## Timing
- `ready` passes through a 2-flop synchroniser and a previous-value flop. The rise is registered action-side on the third clk edge at which `ready` is high, counting the first sampling edge as edge 0. `digits`, `count`, `valid` and `overflow` are visible after edge 2.
- `tecla` is sampled at the same edge the action is registered.
- `valid` and `overflow` are exactly one cycle wide. At most one key action occurs per press.
- Minimum press-to-press spacing: `ready` low for RELEASE_CYC cycles plus the synchroniser latency.
- Reset, asynchronous and active-low, at any time including mid-press:
  - state = IDLE, `digits` = 0, `value` = 0, `count` = 0, `ptr` = NDIGITS-1, `valid` = 0, `overflow` = 0.
  - Synchroniser flops are cleared.
- If `ready` is still high when reset releases, its rise is not seen (previous-value flop is cleared and the synchroniser re-fills). The press executes once, about 2 cycles after release.

## Structure
Package `keypad_pkg`:
- KEY_BKSP = 4'hA, KEY_CLR = 4'hB, KEY_ENT = 4'hC.
- Enum `entry_mode_t` {MODE_WRAP, MODE_SHIFT}.
- FSM state enum.

Sub-module `ready_sync`:
- 2-flop synchroniser plus rise detector.
- Outputs: `ready_s` (level) and `ready_rise` (one-cycle pulse).

## Test plan
- NDIGITS=4, WRAP mode: keys 1,2,3,4 → `digits` = 16'h1234, `count` = 4. Next key 5 → `digits` = 16'h5234, `overflow` pulses once, `count` = 4.
- SHIFT mode: keys 1,2,3,4,5 → `digits` = 16'h2345, `overflow` pulses on 5. Then BKSP → `digits` = 16'h0234, `count` = 3.
- Keys 7,8 then ENT → `value` = 16'h7800 (WRAP) or 16'h0078 (SHIFT), `valid` one cycle wide, `digits` = 0, `count` = 0. CLR afterwards leaves `value` unchanged.
- Bounce: `ready` high 5 cycles, low 2 cycles, high 5 cycles, with RELEASE_CYC = 4 → exactly one digit accepted. Low for 6 cycles before the next press → second digit accepted.
- BKSP with count = 0 → no change. Key code 4'hE → no change, and the FSM still goes through HELD and RELEASE.
- Assert reset while `ready` is high after 3 digits → all outputs 0 immediately. Deassert with `ready` still high → the held key executes once, and no second action occurs until release.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared key codes, fill-mode selector and FSM state encoding for the keypad entry buffer.
package keypad_pkg;

  localparam logic [3:0] KEY_MAX_DIGIT = 4'h9;
  localparam logic [3:0] KEY_BKSP      = 4'hA;
  localparam logic [3:0] KEY_CLR       = 4'hB;
  localparam logic [3:0] KEY_ENT       = 4'hC;

  typedef enum logic {MODE_WRAP, MODE_SHIFT} entry_mode_t;

  typedef enum logic [1:0] {ST_IDLE, ST_HELD, ST_RELEASE} state_t;

endpackage

// File: rtl/ready_sync.sv
// Two-flop synchroniser for the asynchronous keypad strobe, plus a rising-edge detector.
module ready_sync (
  input  logic clk,
  input  logic reset,
  input  logic ready,
  output logic ready_s,
  output logic ready_rise
);

  logic meta;
  logic prev;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta    <= 1'b0;
      ready_s <= 1'b0;
      prev    <= 1'b0;
    end else begin
      meta    <= ready;
      ready_s <= meta;
      prev    <= ready_s;
    end
  end

  assign ready_rise = ready_s & ~prev;

endmodule

// File: rtl/keypad_entry.sv
// N-digit BCD keypad entry buffer with backspace, clear and enter/commit, in wrap or shift fill mode.
// state      | meaning
// ST_IDLE    | waiting for a new press; key action executes on the ready rise
// ST_HELD    | key held; waiting for ready to drop
// ST_RELEASE | ready low; counting down the release window, a re-rise is bounce
module keypad_entry
  import keypad_pkg::*;
#(
  parameter int NDIGITS     = 4,
  parameter int MODE        = 0,
  parameter int RELEASE_CYC = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             ready,
  input  logic [3:0]                       tecla,
  output logic [4*NDIGITS-1:0]             digits,
  output logic [$clog2(NDIGITS+1)-1:0]     count,
  output logic [4*NDIGITS-1:0]             value,
  output logic                             valid,
  output logic                             overflow
);

  localparam int DW = 4 * NDIGITS;
  localparam int CW = $clog2(NDIGITS + 1);
  localparam int PW = $clog2(NDIGITS);
  localparam int RW = (RELEASE_CYC > 1) ? $clog2(RELEASE_CYC) : 1;

  localparam logic [CW-1:0] FULL     = CW'(NDIGITS);
  localparam logic [PW-1:0] PTR_TOP  = PW'(NDIGITS - 1);
  localparam logic [RW-1:0] REL_LOAD = RW'(RELEASE_CYC - 1);
  localparam entry_mode_t   EMODE    = entry_mode_t'(MODE);

  logic          ready_s;
  logic          ready_rise;
  state_t        state;
  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_up;
  logic [PW-1:0] ptr_dn;
  logic [RW-1:0] rel_cnt;

  ready_sync u_sync (
    .clk        (clk),
    .reset      (reset),
    .ready      (ready),
    .ready_s    (ready_s),
    .ready_rise (ready_rise)
  );

  // Explicit modulo so non-power-of-two digit counts wrap correctly.
  assign ptr_dn = (ptr == '0)      ? PTR_TOP : ptr - PW'(1);
  assign ptr_up = (ptr == PTR_TOP) ? '0      : ptr + PW'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      digits   <= '0;
      count    <= '0;
      value    <= '0;
      valid    <= 1'b0;
      overflow <= 1'b0;
      ptr      <= PTR_TOP;
      rel_cnt  <= '0;
    end else begin
      valid    <= 1'b0;
      overflow <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (ready_rise) begin
            state <= ST_HELD;
            if (tecla <= KEY_MAX_DIGIT) begin
              overflow <= (count == FULL);
              if (count != FULL) count <= count + CW'(1);
              if (EMODE == MODE_SHIFT) begin
                digits <= {digits[DW-5:0], tecla};
              end else begin
                digits[{ptr, 2'b00} +: 4] <= tecla;
                ptr <= ptr_dn;
              end
            end else if (tecla == KEY_BKSP) begin
              if (count != '0) begin
                count <= count - CW'(1);
                if (EMODE == MODE_SHIFT) begin
                  digits <= {4'h0, digits[DW-1:4]};
                end else begin
                  digits[{ptr_up, 2'b00} +: 4] <= 4'h0;
                  ptr <= ptr_up;
                end
              end
            end else if (tecla == KEY_CLR || tecla == KEY_ENT) begin
              digits <= '0;
              count  <= '0;
              ptr    <= PTR_TOP;
              if (tecla == KEY_ENT) begin
                value <= digits;
                valid <= 1'b1;
              end
            end
          end
        end
        ST_HELD: begin
          if (!ready_s) begin
            state   <= ST_RELEASE;
            rel_cnt <= REL_LOAD;
          end
        end
        ST_RELEASE: begin
          if (ready_s)              state   <= ST_HELD;
          else if (rel_cnt == '0)   state   <= ST_IDLE;
          else                      rel_cnt <= rel_cnt - RW'(1);
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_entry.sv
// Bench for keypad_entry: WRAP and SHIFT instances share stimulus and are checked against a behavioural model.
module tb_keypad_entry;
  localparam int ND = 4;
  localparam int RC = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        ready;
  logic [3:0]  tecla;
  logic [15:0] digits_w, digits_s, value_w, value_s;
  logic [2:0]  count_w, count_s;
  logic        valid_w, valid_s, overflow_w, overflow_s;

  always #5 clk = ~clk;

  keypad_entry #(.NDIGITS(ND), .MODE(0), .RELEASE_CYC(RC)) dut_w (
    .clk(clk), .reset(reset), .ready(ready), .tecla(tecla),
    .digits(digits_w), .count(count_w), .value(value_w),
    .valid(valid_w), .overflow(overflow_w));

  keypad_entry #(.NDIGITS(ND), .MODE(1), .RELEASE_CYC(RC)) dut_s (
    .clk(clk), .reset(reset), .ready(ready), .tecla(tecla),
    .digits(digits_s), .count(count_s), .value(value_s),
    .valid(valid_s), .overflow(overflow_s));

  int n_cmp = 0;
  int n_bad = 0;
  int pv_w, pv_s, po_w, po_s;

  // Reference model: WRAP buffer as nibble array with a fill pointer, SHIFT buffer as base-16 number.
  logic [15:0] mw_dig, ms_dig, mw_val, ms_val;
  int          mw_ptr, mw_cnt, ms_cnt;
  int          e_ovf_w, e_ovf_s, e_valid;

  task automatic model_clear();
    mw_dig = '0; ms_dig = '0; mw_cnt = 0; ms_cnt = 0; mw_ptr = ND - 1;
  endtask

  task automatic model_reset();
    model_clear();
    mw_val = '0; ms_val = '0;
  endtask

  task automatic model_key(input logic [3:0] k);
    e_ovf_w = 0; e_ovf_s = 0; e_valid = 0;
    if (k <= 4'd9) begin
      e_ovf_w = (mw_cnt == ND) ? 1 : 0;
      e_ovf_s = (ms_cnt == ND) ? 1 : 0;
      mw_dig = (mw_dig & ~(16'hF << (4 * mw_ptr))) | (16'(k) << (4 * mw_ptr));
      mw_ptr = (mw_ptr + ND - 1) % ND;
      if (mw_cnt < ND) mw_cnt++;
      ms_dig = (ms_dig << 4) | 16'(k);
      if (ms_cnt < ND) ms_cnt++;
    end else if (k == 4'hA) begin
      if (mw_cnt > 0) begin
        mw_ptr = (mw_ptr + 1) % ND;
        mw_dig = mw_dig & ~(16'hF << (4 * mw_ptr));
        mw_cnt--;
      end
      if (ms_cnt > 0) begin
        ms_dig = ms_dig >> 4;
        ms_cnt--;
      end
    end else if (k == 4'hB) begin
      model_clear();
    end else if (k == 4'hC) begin
      mw_val = mw_dig; ms_val = ms_dig; e_valid = 1;
      model_clear();
    end
  endtask

  task automatic run(input logic lvl, input int n);
    ready = lvl;
    repeat (n) begin
      @(negedge clk);
      pv_w += 32'(valid_w);    pv_s += 32'(valid_s);
      po_w += 32'(overflow_w); po_s += 32'(overflow_s);
    end
  endtask

  task automatic clear_tally();
    pv_w = 0; pv_s = 0; po_w = 0; po_s = 0;
  endtask

  task automatic press(input logic [3:0] k, input int hold);
    clear_tally();
    tecla = k;
    run(1'b1, hold);
    run(1'b0, 8);
    tecla = 4'($urandom_range(0, 15));
  endtask

  task automatic test_reset();
    reset = 1'b0; ready = 1'b0; tecla = 4'h0;
    model_reset();
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({digits_w, digits_s, value_w, value_s} !== 64'h0) begin
      n_bad++; $display("FAIL reset_data got %h %h %h %h want 0", digits_w, digits_s, value_w, value_s);
    end
    n_cmp++;
    if ({count_w, count_s, valid_w, valid_s, overflow_w, overflow_s} !== 10'h0) begin
      n_bad++; $display("FAIL reset_ctrl got cnt %0d %0d vld %b %b ovf %b %b want 0",
                        count_w, count_s, valid_w, valid_s, overflow_w, overflow_s);
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_fill();
    logic [3:0] keys [6];
    keys = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'hA};
    for (int i = 0; i < 6; i++) begin
      model_key(keys[i]);
      press(keys[i], 5);
      n_cmp++;
      if (digits_w !== mw_dig || int'(count_w) !== mw_cnt || po_w !== e_ovf_w) begin
        n_bad++; $display("FAIL fill_wrap key %h got %h/%0d/ovf%0d want %h/%0d/ovf%0d",
                          keys[i], digits_w, count_w, po_w, mw_dig, mw_cnt, e_ovf_w);
      end
      n_cmp++;
      if (digits_s !== ms_dig || int'(count_s) !== ms_cnt || po_s !== e_ovf_s) begin
        n_bad++; $display("FAIL fill_shift key %h got %h/%0d/ovf%0d want %h/%0d/ovf%0d",
                          keys[i], digits_s, count_s, po_s, ms_dig, ms_cnt, e_ovf_s);
      end
      if (i == 3) begin
        n_cmp++;
        if (digits_w !== 16'h1234 || count_w !== 3'd4) begin
          n_bad++; $display("FAIL wrap_1234 got %h/%0d want 1234/4", digits_w, count_w);
        end
      end
      if (i == 4) begin
        n_cmp++;
        if (digits_w !== 16'h5234 || digits_s !== 16'h2345 || po_w !== 1 || po_s !== 1) begin
          n_bad++; $display("FAIL overflow_key5 got %h %h ovf %0d %0d want 5234 2345 ovf 1 1",
                            digits_w, digits_s, po_w, po_s);
        end
      end
      if (i == 5) begin
        n_cmp++;
        if (digits_s !== 16'h0234 || count_s !== 3'd3) begin
          n_bad++; $display("FAIL shift_bksp got %h/%0d want 0234/3", digits_s, count_s);
        end
      end
    end
  endtask

  task automatic test_commit();
    logic [3:0] keys [5];
    keys = '{4'hB, 4'h7, 4'h8, 4'hC, 4'hB};
    for (int i = 0; i < 5; i++) begin
      model_key(keys[i]);
      press(keys[i], 4);
      n_cmp++;
      if (digits_w !== mw_dig || digits_s !== ms_dig || int'(count_w) !== mw_cnt || int'(count_s) !== ms_cnt) begin
        n_bad++; $display("FAIL commit_buf key %h got %h %h %0d %0d want %h %h %0d %0d",
                          keys[i], digits_w, digits_s, count_w, count_s, mw_dig, ms_dig, mw_cnt, ms_cnt);
      end
      n_cmp++;
      if (value_w !== mw_val || value_s !== ms_val || pv_w !== e_valid || pv_s !== e_valid) begin
        n_bad++; $display("FAIL commit_val key %h got %h %h vld %0d %0d want %h %h vld %0d",
                          keys[i], value_w, value_s, pv_w, pv_s, mw_val, ms_val, e_valid);
      end
    end
    n_cmp++;
    if (value_w !== 16'h7800 || value_s !== 16'h0078) begin
      n_bad++; $display("FAIL commit_78 got %h %h want 7800 0078", value_w, value_s);
    end
  endtask

  task automatic test_bounce();
    clear_tally();
    tecla = 4'h3;
    run(1'b1, 5); run(1'b0, 2); run(1'b1, 5); run(1'b0, 6);
    model_key(4'h3);
    n_cmp++;
    if (digits_w !== mw_dig || digits_s !== ms_dig || int'(count_s) !== ms_cnt) begin
      n_bad++; $display("FAIL bounce_once got %h %h %0d want %h %h %0d",
                        digits_w, digits_s, count_s, mw_dig, ms_dig, ms_cnt);
    end
    tecla = 4'h9;
    run(1'b1, 5); run(1'b0, 8);
    model_key(4'h9);
    n_cmp++;
    if (digits_w !== mw_dig || digits_s !== ms_dig || int'(count_w) !== mw_cnt) begin
      n_bad++; $display("FAIL bounce_next got %h %h %0d want %h %h %0d",
                        digits_w, digits_s, count_w, mw_dig, ms_dig, mw_cnt);
    end
  endtask

  task automatic test_ignored();
    model_key(4'hB); press(4'hB, 4);
    model_key(4'hA); press(4'hA, 4);
    n_cmp++;
    if (digits_w !== 16'h0 || digits_s !== 16'h0 || count_w !== 3'd0 || count_s !== 3'd0) begin
      n_bad++; $display("FAIL bksp_empty got %h %h %0d %0d want 0", digits_w, digits_s, count_w, count_s);
    end
    model_key(4'h4); press(4'h4, 4);
    // Key E, then a re-press inside its release window: must be discarded as bounce.
    clear_tally();
    model_key(4'hE);
    tecla = 4'hE; run(1'b1, 5); run(1'b0, 3);
    tecla = 4'h6; run(1'b1, 5); run(1'b0, 8);
    n_cmp++;
    if (digits_w !== mw_dig || digits_s !== ms_dig || int'(count_w) !== mw_cnt || (pv_w + po_w) !== 0) begin
      n_bad++; $display("FAIL ignored_key got %h %h %0d want %h %h %0d",
                        digits_w, digits_s, count_w, mw_dig, ms_dig, mw_cnt);
    end
  endtask

  task automatic test_reset_midpress();
    model_key(4'hB); press(4'hB, 4);
    model_key(4'h1); press(4'h1, 4);
    model_key(4'h2); press(4'h2, 4);
    model_key(4'h3); press(4'h3, 4);
    tecla = 4'h6; ready = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({digits_w, digits_s, value_w, value_s} !== 64'h0 ||
        {count_w, count_s, valid_w, valid_s, overflow_w, overflow_s} !== 10'h0) begin
      n_bad++; $display("FAIL midpress_reset got %h %h %0d %0d want 0", digits_w, digits_s, count_w, count_s);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    model_reset();
    model_key(4'h6);
    clear_tally();
    run(1'b1, 6);
    n_cmp++;
    if (digits_w !== mw_dig || digits_s !== ms_dig || int'(count_w) !== mw_cnt) begin
      n_bad++; $display("FAIL held_after_reset got %h %h %0d want %h %h %0d",
                        digits_w, digits_s, count_w, mw_dig, ms_dig, mw_cnt);
    end
    run(1'b1, 4); run(1'b0, 8);
    n_cmp++;
    if (digits_s !== ms_dig || int'(count_s) !== ms_cnt) begin
      n_bad++; $display("FAIL held_once got %h/%0d want %h/%0d", digits_s, count_s, ms_dig, ms_cnt);
    end
  endtask

  task automatic test_random();
    logic [3:0] k;
    for (int i = 0; i < 40; i++) begin
      k = 4'($urandom_range(0, 15));
      model_key(k);
      press(k, $urandom_range(3, 7));
      n_cmp++;
      if (digits_w !== mw_dig || int'(count_w) !== mw_cnt || value_w !== mw_val ||
          pv_w !== e_valid || po_w !== e_ovf_w) begin
        n_bad++; $display("FAIL rand_wrap #%0d key %h got %h/%0d/%h/v%0d/o%0d want %h/%0d/%h/v%0d/o%0d",
                          i, k, digits_w, count_w, value_w, pv_w, po_w, mw_dig, mw_cnt, mw_val, e_valid, e_ovf_w);
      end
      n_cmp++;
      if (digits_s !== ms_dig || int'(count_s) !== ms_cnt || value_s !== ms_val ||
          pv_s !== e_valid || po_s !== e_ovf_s) begin
        n_bad++; $display("FAIL rand_shift #%0d key %h got %h/%0d/%h/v%0d/o%0d want %h/%0d/%h/v%0d/o%0d",
                          i, k, digits_s, count_s, value_s, pv_s, po_s, ms_dig, ms_cnt, ms_val, e_valid, e_ovf_s);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fill();
    test_commit();
    test_bounce();
    test_ignored();
    test_reset_midpress();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
